// File: rtl/mixer_pkg.sv
// mixer_pkg: shared encodings for the mixer sequencer
package mixer_pkg;
    localparam logic [1:0] MIX_BG      = 2'd0;
    localparam logic [1:0] MIX_FG      = 2'd1;
    localparam logic [1:0] MIX_KEY     = 2'd2;
    localparam logic [1:0] MIX_BLACK   = 2'd3;
    localparam logic [1:0] ADDR_MODE   = 2'd0;
    localparam logic [1:0] ADDR_KEY    = 2'd1;
    localparam logic [1:0] ADDR_MUTE   = 2'd2;
    localparam logic [1:0] ADDR_COMMIT = 2'd3;
    typedef enum logic [1:0] {IDLE, PENDING, MUTE} state_e;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: registers a synchronous strobe and flags its rising edge
module sync_edge_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic rise_o
);
    logic sig_q;
    always_ff @(posedge clk_i) begin
        if (!rst_ni) sig_q <= 1'b0;
        else         sig_q <= sig_i;
    end
    assign rise_o = sig_i && !sig_q;
endmodule

// File: rtl/mixer_sequencer.sv
// mixer_sequencer: stages host config and applies it to the live mixer controls at field boundaries
module mixer_sequencer
    import mixer_pkg::*;
#(
    parameter logic [1:0]  DEFAULT_MODE = MIX_KEY,
    parameter logic [17:0] DEFAULT_KEY  = 18'h00000
) (
    input  logic        pixelClockX6,
    input  logic        nReset,
    input  logic        vsync,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [1:0]  cfg_addr,
    input  logic [17:0] cfg_data,
    output logic [1:0]  mix_mode,
    output logic [17:0] key_colour,
    output logic        mute,
    output logic        busy
);
    state_e      state_q, state_d;
    logic [1:0]  stg_mode_q, stg_mode_d, mode_q, mode_d;
    logic [17:0] stg_key_q, stg_key_d, key_q, key_d;
    logic [3:0]  stg_mute_q, stg_mute_d, cnt_q, cnt_d;
    logic        mute_q, mute_d, alive_q, vsync_rise, wr;

    sync_edge_detect u_vs (
        .clk_i  (pixelClockX6),
        .rst_ni (nReset),
        .sig_i  (vsync),
        .rise_o (vsync_rise)
    );

    // alive_q keeps cfg_ready low while reset is held, without a path from nReset
    assign cfg_ready  = alive_q && (state_q == IDLE);
    assign busy       = state_q != IDLE;
    assign wr         = cfg_valid && cfg_ready;
    assign mix_mode   = mode_q;
    assign key_colour = key_q;
    assign mute       = mute_q;

    always_comb begin
        state_d    = state_q;
        stg_mode_d = (wr && cfg_addr == ADDR_MODE) ? cfg_data[1:0] : stg_mode_q;
        stg_key_d  = (wr && cfg_addr == ADDR_KEY)  ? cfg_data      : stg_key_q;
        stg_mute_d = (wr && cfg_addr == ADDR_MUTE) ? cfg_data[3:0] : stg_mute_q;
        mode_d     = mode_q;
        key_d      = key_q;
        mute_d     = mute_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: state_d = (wr && cfg_addr == ADDR_COMMIT) ? PENDING : IDLE;
            PENDING: if (vsync_rise) begin
                mode_d  = stg_mode_q;
                key_d   = stg_key_q;
                mute_d  = stg_mute_q != 4'd0;
                cnt_d   = stg_mute_q;
                state_d = (stg_mute_q != 4'd0) ? MUTE : IDLE;
            end
            MUTE: if (vsync_rise) begin
                mute_d  = cnt_q != 4'd1;
                cnt_d   = cnt_q - 4'd1;
                state_d = (cnt_q == 4'd1) ? IDLE : MUTE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pixelClockX6) begin
        if (!nReset) begin
            state_q    <= IDLE;
            alive_q    <= 1'b0;
            stg_mode_q <= DEFAULT_MODE;
            stg_key_q  <= DEFAULT_KEY;
            stg_mute_q <= 4'd0;
            mode_q     <= DEFAULT_MODE;
            key_q      <= DEFAULT_KEY;
            mute_q     <= 1'b0;
            cnt_q      <= 4'd0;
        end else begin
            state_q    <= state_d;
            alive_q    <= 1'b1;
            stg_mode_q <= stg_mode_d;
            stg_key_q  <= stg_key_d;
            stg_mute_q <= stg_mute_d;
            mode_q     <= mode_d;
            key_q      <= key_d;
            mute_q     <= mute_d;
            cnt_q      <= cnt_d;
        end
    end
endmodule

// File: tb/tb_mixer_sequencer.sv
// tb_mixer_sequencer: scoreboard bench for the field-synchronous config sequencer
module tb_mixer_sequencer;
    typedef struct packed {
        logic [1:0]  mode;
        logic [17:0] key;
        logic        mute;
    } live_t;

    logic        clk = 1'b0, nReset = 1'b0, vsync = 1'b0, cfg_valid = 1'b0;
    logic [1:0]  cfg_addr = 2'd0;
    logic [17:0] cfg_data = 18'd0;
    logic        cfg_ready, mute, busy;
    logic [1:0]  mix_mode;
    logic [17:0] key_colour;
    int          n_chk = 0, n_err = 0;
    live_t       sb[$];
    live_t       prev, e;
    logic        mon_en = 1'b0;

    mixer_sequencer dut (
        .pixelClockX6 (clk),
        .nReset       (nReset),
        .vsync        (vsync),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .mix_mode     (mix_mode),
        .key_colour   (key_colour),
        .mute         (mute),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [17:0] d);
        int n = 0;
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_data  = d;
        while (!cfg_ready && n < 200) begin
            tick();
            n++;
        end
        if (n == 200) chk("wr_timeout", 0, 1);
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic pulse(input int hi);
        vsync = 1'b1;
        repeat (hi) tick();
        vsync = 1'b0;
        tick();
    endtask

    // Every change of the live controls must match the next scoreboard entry
    always @(negedge clk) begin
        if (mon_en && live_t'({mix_mode, key_colour, mute}) != prev) begin
            if (sb.size() == 0) chk("sb_unexpected", {mix_mode, key_colour, mute}, prev);
            else begin
                e = sb.pop_front();
                chk("sb_mode", mix_mode, e.mode);
                chk("sb_key", key_colour, e.key);
                chk("sb_mute", mute, e.mute);
            end
            prev = {mix_mode, key_colour, mute};
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        chk("rst_ready", cfg_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mode", mix_mode, 2);
        chk("rst_key", key_colour, 0);
        chk("rst_mute", mute, 0);
        nReset = 1'b1;
        tick();
        chk("rel_ready", cfg_ready, 1);
        chk("rel_busy", busy, 0);
        prev   = {2'd2, 18'd0, 1'b0};
        mon_en = 1'b1;

        wr(2'd0, 18'h3FFFD);
        wr(2'd2, 18'h3FFF0);
        wr(2'd3, 18'h0);
        sb.push_back({2'd1, 18'd0, 1'b0});
        chk("pend_busy", busy, 1);
        chk("pend_ready", cfg_ready, 0);
        repeat (40) tick();
        vsync = 1'b1;
        chk("pre_vs_mode", mix_mode, 2);
        tick();
        chk("post_vs_mode", mix_mode, 1);
        chk("post_vs_busy", busy, 0);
        vsync = 1'b0;
        tick();

        wr(2'd1, 18'h3F000);
        wr(2'd2, 18'h3);
        wr(2'd3, 18'h0);
        sb.push_back({2'd1, 18'h3F000, 1'b1});
        repeat (5) tick();
        vsync = 1'b1;
        tick();
        chk("m_key", key_colour, 18'h3F000);
        chk("m_mute_on", mute, 1);
        chk("m_ready0", cfg_ready, 0);
        repeat (10) tick();
        vsync = 1'b0;
        tick();
        pulse(12);
        chk("m_rise1", mute, 1);
        pulse(3);
        chk("m_rise2", mute, 1);
        chk("m_ready2", cfg_ready, 0);
        sb.push_back({2'd1, 18'h3F000, 1'b0});
        vsync = 1'b1;
        tick();
        chk("m_rise3", mute, 0);
        chk("m_idle_busy", busy, 0);
        chk("m_idle_ready", cfg_ready, 1);
        vsync = 1'b0;
        tick();

        wr(2'd0, 18'h0);
        wr(2'd2, 18'h0);
        cfg_valid = 1'b1;
        cfg_addr  = 2'd3;
        vsync     = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("same_mode", mix_mode, 1);
        chk("same_busy", busy, 1);
        repeat (4) tick();
        chk("same_hold", mix_mode, 1);
        vsync = 1'b0;
        tick();
        sb.push_back({2'd0, 18'h3F000, 1'b0});
        vsync = 1'b1;
        tick();
        chk("next_mode", mix_mode, 0);
        chk("next_busy", busy, 0);
        vsync = 1'b0;
        tick();

        wr(2'd2, 18'h2);
        wr(2'd3, 18'h0);
        sb.push_back({2'd0, 18'h3F000, 1'b1});
        pulse(1);
        cfg_valid = 1'b1;
        cfg_addr  = 2'd0;
        cfg_data  = 18'h3;
        tick();
        chk("hold_ready", cfg_ready, 0);
        pulse(1);
        chk("hold_mute", mute, 1);
        chk("hold_mode", mix_mode, 0);
        sb.push_back({2'd0, 18'h3F000, 1'b0});
        vsync = 1'b1;
        tick();
        chk("hold_idle_ready", cfg_ready, 1);
        vsync = 1'b0;
        tick();
        cfg_valid = 1'b0;
        chk("hold_after_ready", cfg_ready, 1);
        wr(2'd2, 18'h0);
        wr(2'd3, 18'h0);
        sb.push_back({2'd3, 18'h3F000, 1'b0});
        pulse(2);
        chk("hold_mode_live", mix_mode, 3);

        wr(2'd1, 18'h15555);
        wr(2'd2, 18'h3);
        wr(2'd3, 18'h0);
        sb.push_back({2'd3, 18'h15555, 1'b1});
        pulse(1);
        pulse(1);
        chk("pre_rst_mute", mute, 1);
        mon_en = 1'b0;
        nReset = 1'b0;
        tick();
        chk("mrst_mute", mute, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_mode", mix_mode, 2);
        chk("mrst_key", key_colour, 0);
        chk("mrst_ready", cfg_ready, 0);
        nReset = 1'b1;
        tick();
        chk("mrst_rel_ready", cfg_ready, 1);
        prev   = {2'd2, 18'd0, 1'b0};
        mon_en = 1'b1;
        pulse(2);
        chk("mrst_vs_mode", mix_mode, 2);
        chk("mrst_vs_mute", mute, 0);
        wr(2'd3, 18'h0);
        pulse(2);
        chk("mrst_commit_mode", mix_mode, 2);
        chk("mrst_commit_key", key_colour, 0);
        chk("mrst_commit_busy", busy, 0);
        tick();
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/mixer_sequencer.md
# mixer_sequencer

Configuration and sequencing controller for the PAL 576i video mixer. Holds host-written staging values for mix mode, key colour and mute length. On a host commit it transfers them to the live mixer controls only at the next field boundary (vsync rising edge). It optionally forces the mixer output to black for a programmed number of fields so that source switches never tear mid-field.

## Interface
Parameters:
- DEFAULT_MODE, 2'd2, mix mode after reset (keyed overlay)
- DEFAULT_KEY, 18'h00000, key colour after reset ({r,g,b} 6 bits each, black)

Ports:
- pixelClockX6  in  1  system clock; the only clock
- nReset  in  1  reset, synchronous, active-low
- vsync  in  1  field sync, active-high, synchronous to pixelClockX6
- cfg_valid  in  1  host write request
- cfg_ready  out  1  host write accept; a transfer occurs on an edge where valid && ready
- cfg_addr  in  2  register select: 0 mode, 1 key colour, 2 mute fields, 3 commit
- cfg_data  in  18  write data
- mix_mode  out  2  live mode: 0 background only, 1 foreground only, 2 keyed (fg unless fg == key_colour), 3 black
- key_colour  out  18  live key colour {r[5:0], g[5:0], b[5:0]}
- mute  out  1  force mixer output black
- busy  out  1  commit pending or mute in progress

## Operation
- Staging registers:
  - stg_mode[1:0] at addr 0, from cfg_data[1:0].
  - stg_key[17:0] at addr 1.
  - stg_mute[3:0] at addr 2, from cfg_data[3:0].
  - Upper data bits are ignored.
- Addr 3 write (data ignored) is a commit request.
- vsync_rise = vsync && !vsync_q. vsync_q is registered every clock.
- State machine:
  - IDLE
    - cfg_ready = 1.
    - Staging writes are accepted.
    - A commit moves to PENDING.
  - PENDING
    - cfg_ready = 0.
    - On vsync_rise: mix_mode <= stg_mode, key_colour <= stg_key.
    - If stg_mute == 0, go to IDLE.
    - Otherwise mute <= 1, mute_cnt <= stg_mute, go to MUTE.
  - MUTE
    - cfg_ready = 0.
    - On each vsync_rise, mute_cnt decrements.
    - On the vsync_rise where mute_cnt == 1: mute <= 0, mute_cnt <= 0, go to IDLE.
- busy = (state != IDLE). Decoded combinationally from the state register.
- Live outputs change only in PENDING→{IDLE, MUTE} transitions and MUTE→IDLE. Staging writes never affect live outputs directly.
- Commit accepted on the same edge that a vsync_rise is present: that rise is not used. The transfer waits for the next rise.
- stg_mute is sampled at the PENDING transfer edge. Staging cannot change in MUTE because cfg_ready = 0.
- Reset while nReset = 0, at any edge and in any state:
  - State <= IDLE.
  - mix_mode <= DEFAULT_MODE, key_colour <= DEFAULT_KEY, mute <= 0, mute_cnt <= 0.
  - Staging registers take the same defaults; stg_mute <= 0.
  - vsync_q <= 0.

## Timing
- Reset values:
  - cfg_ready = 0 while nReset = 0; 1 on the first edge after release (IDLE).
  - busy = 0, mute = 0, mix_mode = DEFAULT_MODE, key_colour = DEFAULT_KEY.
- Handshake: cfg_ready depends only on state, not on cfg_valid. There is no combinational path from cfg_valid to cfg_ready.
- Latency: live outputs update on the clock edge following the first cycle with vsync high after vsync_q was low. mute asserts on that same edge.
- Mute duration is exactly stg_mute fields (1..15). Deassertion occurs on the edge after the stg_mute-th subsequent vsync rise is sampled.
- vsync held high for many cycles counts as one rise.
- All outputs are registered, except busy and cfg_ready, which decode the state register.

## Structure
- Shared package mixer_pkg:
  - mode encoding constants: MIX_BG, MIX_FG, MIX_KEY, MIX_BLACK
  - register address constants: ADDR_MODE, ADDR_KEY, ADDR_MUTE, ADDR_COMMIT
  - state encoding: IDLE, PENDING, MUTE
- One sub-module, sync_edge_detect: registers vsync and produces the vsync_rise pulse. It uses the same clock and synchronous reset.
- The videomixer itself is unchanged apart from consuming mix_mode, key_colour and mute.

## Test plan
- Reset release → mix_mode = 2, key_colour = 0, mute = 0, busy = 0, cfg_ready = 1 on the first edge.
- Write mode = 1, mute = 0, commit; pulse vsync 40 cycles later → mix_mode stays 2 until the edge after vsync goes high, then becomes 1; busy returns to 0 on that edge.
- Write key = 18'h3F000, mute = 3, commit → on the first vsync rise key updates and mute = 1; mute clears on the edge after the 3rd subsequent rise; cfg_ready = 0 throughout.
- Commit accepted in the same cycle as a vsync rise → no update on that rise; update occurs on the following rise.
- Hold cfg_valid high with addr 0 during MUTE → no transfer; stg_mode is unchanged; the write completes on the first IDLE edge.
- Assert nReset = 0 mid-MUTE (mute_cnt = 2) → next edge: mute = 0, state IDLE, outputs at defaults, a later vsync causes no change.
